// File: rtl/gate_tst_pkg.sv
// Shared definitions for the 3-input gate vector exerciser.
//   state_t       : sweep controller states
//   TRUTH_*       : ready-made truth tables, bit k = expected y for x == k
//   SETTLE_MIN    : shortest legal hold time, covers the 2-flop input synchronizer
//   clamp_settle  : maps a requested settle time onto the legal range
package gate_tst_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [7:0] TRUTH_OR3  = 8'hFE;
  localparam logic [7:0] TRUTH_NOR3 = 8'h01;
  localparam logic [7:0] TRUTH_AND3 = 8'h80;

  localparam int SETTLE_MIN = 3;

  // Anything shorter than the synchronizer latency would sample a stale y,
  // and the settle counter is only 8 bits wide.
  function automatic int clamp_settle(input int requested);
    if (requested < SETTLE_MIN) return SETTLE_MIN;
    if (requested > 255) return 255;
    return requested;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit.
//   clk   : destination clock, rising edge
//   rst_n : asynchronous active-low reset, both flops clear to 0
//   d     : asynchronous input
//   q     : synchronized output, two clk edges behind d
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gate3_vector_exerciser.sv
// Built-in self-test stage for a 3-input gate. A start pulse sweeps x through
// codes 0..7, holding each for SETTLE_CYCLES cycles plus one sample cycle, and
// compares the synchronized gate output against the TRUTH table.
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   start      : request a full sweep (accepted in IDLE or DONE)
//   abort      : cancel a running sweep, back to IDLE, results kept
//   y_in       : gate output, asynchronous to clk
//   x          : vector driven to the gate
//   busy, done : sweep in progress / sweep finished
//   pass       : valid with done, 1 when no code mismatched
//   err_count  : number of mismatching codes
//   fail_seen  : at least one mismatch so far
//   first_fail : lowest mismatching code, 0 if none
module gate3_vector_exerciser
  import gate_tst_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 5,
  parameter logic [7:0] TRUTH         = 8'hFE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       y_in,
  output logic [2:0] x,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic       fail_seen,
  output logic [2:0] first_fail
);

  localparam int         SETTLE_EFF = clamp_settle(SETTLE_CYCLES);
  // The counter runs down to 0 inclusive, so loading N-1 gives N cycles in SETTLE.
  localparam logic [7:0] RELOAD     = 8'(SETTLE_EFF - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] x_d;
  logic       busy_d, done_d, pass_d, fail_seen_d;
  logic [3:0] err_count_d, err_next;
  logic [2:0] first_fail_d;
  logic       y_sync;
  logic       mismatch;

  sync2 u_sync_y (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (y_in),
    .q     (y_sync)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      x          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_seen  <= 1'b0;
      first_fail <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      x          <= x_d;
      busy       <= busy_d;
      done       <= done_d;
      pass       <= pass_d;
      err_count  <= err_count_d;
      fail_seen  <= fail_seen_d;
      first_fail <= first_fail_d;
    end
  end

  // Abort is checked before the compare so an aborted sample cycle never
  // reaches the result registers. pass uses the post-increment count so the
  // final code's mismatch is included in the verdict.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    x_d          = x;
    busy_d       = busy;
    done_d       = done;
    pass_d       = pass;
    err_count_d  = err_count;
    fail_seen_d  = fail_seen;
    first_fail_d = first_fail;
    mismatch     = y_sync ^ TRUTH[x];
    err_next     = err_count + {3'b000, mismatch};

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = SETTLE;
          cnt_d        = RELOAD;
          x_d          = '0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          err_count_d  = '0;
          fail_seen_d  = 1'b0;
          first_fail_d = '0;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          x_d     = '0;
        end else if (cnt_q == 8'd0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      SAMPLE: begin
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          x_d     = '0;
        end else begin
          err_count_d = err_next;
          if (mismatch && !fail_seen) begin
            first_fail_d = x;
            fail_seen_d  = 1'b1;
          end
          if (x == 3'd7) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_next == 4'd0);
          end else begin
            x_d     = x + 3'd1;
            cnt_d   = RELOAD;
            state_d = SETTLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gate3_vector_exerciser.sv
// Self-checking bench: two exerciser instances (OR3 table with default settle,
// NOR3 table with a settle request below the minimum) wrapped around a
// behavioural gate whose truth table the bench picks per sweep.
module tb_gate3_vector_exerciser;

  localparam int         A_SETTLE = 5;
  localparam logic [7:0] A_TRUTH  = 8'hFE;
  localparam int         B_SETTLE = 1;
  localparam logic [7:0] B_TRUTH  = 8'h01;
  localparam int A_LAT = 8 * (((A_SETTLE < 3) ? 3 : A_SETTLE) + 1);
  localparam int B_LAT = 8 * (((B_SETTLE < 3) ? 3 : B_SETTLE) + 1);

  typedef struct {
    int err;
    int first;
    int fs;
    int ps;
    int done_cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb, part;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
  logic [7:0] gate_a = 8'hFE, gate_b = 8'h01;
  logic y_in_a, y_in_b;
  logic [2:0] x_a, x_b, first_fail_a, first_fail_b;
  logic busy_a, done_a, pass_a, fail_seen_a;
  logic busy_b, done_b, pass_b, fail_seen_b;
  logic [3:0] err_count_a, err_count_b;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit prev_a = 1'b0, prev_b = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  assign y_in_a = gate_a[x_a];
  assign y_in_b = gate_b[x_b];

  gate3_vector_exerciser #(.SETTLE_CYCLES(A_SETTLE), .TRUTH(A_TRUTH)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .y_in(y_in_a),
    .x(x_a), .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_count_a),
    .fail_seen(fail_seen_a), .first_fail(first_fail_a)
  );

  gate3_vector_exerciser #(.SETTLE_CYCLES(B_SETTLE), .TRUTH(B_TRUTH)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .y_in(y_in_b),
    .x(x_b), .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_count_b),
    .fail_seen(fail_seen_b), .first_fail(first_fail_b)
  );

  task automatic checkOutput(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: walk the codes actually sampled and compare gate vs. table.
  function automatic exp_t refModel(input logic [7:0] g, input logic [7:0] t,
                                    input int upto, input int done_cyc);
    exp_t e;
    e.err = 0; e.first = 0; e.fs = 0;
    for (int k = 0; k < upto; k++) begin
      if (g[k] != t[k]) begin
        e.err++;
        if (e.fs == 0) begin
          e.first = k;
          e.fs = 1;
        end
      end
    end
    e.ps = (e.err == 0) ? 1 : 0;
    e.done_cyc = done_cyc;
    return e;
  endfunction

  task automatic applyStimulus(input int inst, input bit st, input bit ab);
    if (inst == 0) begin start_a = st; abort_a = ab; end
    else begin start_b = st; abort_b = ab; end
    @(negedge clk);
    start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
  endtask

  task automatic startSweep(input int inst, input logic [7:0] g);
    if (inst == 0) begin
      gate_a = g;
      qa.push_back(refModel(g, A_TRUTH, 8, cyc + A_LAT + 1));
    end else begin
      gate_b = g;
      qb.push_back(refModel(g, B_TRUTH, 8, cyc + B_LAT + 1));
    end
    applyStimulus(inst, 1'b1, 1'b0);
  endtask

  task automatic waitDone(input int inst);
    int n = 0;
    if (inst == 0) begin
      while (qa.size() != 0 && n < 500) begin @(negedge clk); n++; end
      if (qa.size() != 0) begin checkOutput("a_sweep_timeout", 0, 1); qa.delete(); end
    end else begin
      while (qb.size() != 0 && n < 500) begin @(negedge clk); n++; end
      if (qb.size() != 0) begin checkOutput("b_sweep_timeout", 0, 1); qb.delete(); end
    end
  endtask

  // Monitors: compare results on each rising edge of done.
  always @(negedge clk) begin
    if (done_a && !prev_a) begin
      if (qa.size() == 0) checkOutput("a_unexpected_done", 1, 0);
      else begin
        ea = qa.pop_front();
        checkOutput("a_err_count", err_count_a, ea.err);
        checkOutput("a_first_fail", first_fail_a, ea.first);
        checkOutput("a_fail_seen", fail_seen_a, ea.fs);
        checkOutput("a_pass", pass_a, ea.ps);
        checkOutput("a_x_at_done", x_a, 7);
        checkOutput("a_busy_at_done", busy_a, 0);
        checkOutput("a_done_cycle", cyc, ea.done_cyc);
      end
    end
    prev_a = done_a;
  end

  always @(negedge clk) begin
    if (done_b && !prev_b) begin
      if (qb.size() == 0) checkOutput("b_unexpected_done", 1, 0);
      else begin
        eb = qb.pop_front();
        checkOutput("b_err_count", err_count_b, eb.err);
        checkOutput("b_first_fail", first_fail_b, eb.first);
        checkOutput("b_fail_seen", fail_seen_b, eb.fs);
        checkOutput("b_pass", pass_b, eb.ps);
        checkOutput("b_x_at_done", x_b, 7);
        checkOutput("b_done_cycle", cyc, eb.done_cyc);
      end
    end
    prev_b = done_b;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected test end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] g;
    #1;
    checkOutput("rst_x", x_a, 0);
    checkOutput("rst_busy", busy_a, 0);
    checkOutput("rst_done", done_a, 0);
    checkOutput("rst_pass", pass_a, 0);
    checkOutput("rst_err", err_count_a, 0);
    checkOutput("rst_fail_seen", fail_seen_a, 0);
    checkOutput("rst_first_fail", first_fail_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Correct OR3, stuck-at-0, NOR3 against the OR3 table.
    startSweep(0, 8'hFE); waitDone(0);
    startSweep(0, 8'h00); waitDone(0);
    startSweep(0, 8'h01); waitDone(0);

    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      startSweep(0, 8'($urandom));
      waitDone(0);
    end

    // Instance B: NOR3 table, clamped settle time.
    startSweep(1, 8'h01); waitDone(1);
    startSweep(1, 8'hFE); waitDone(1);
    for (int i = 0; i < 2; i++) begin
      startSweep(1, 8'($urandom));
      waitDone(1);
    end

    // start while x == 4 is ignored; the sweep finishes on schedule.
    startSweep(0, 8'($urandom));
    repeat (25) @(negedge clk);
    applyStimulus(0, 1'b1, 1'b0);
    waitDone(0);

    // start in DONE restarts on the next edge.
    g = 8'($urandom);
    startSweep(0, g);
    checkOutput("restart_done", done_a, 0);
    checkOutput("restart_busy", busy_a, 1);
    checkOutput("restart_err", err_count_a, 0);
    checkOutput("restart_fail_seen", fail_seen_a, 0);
    checkOutput("restart_x", x_a, 0);
    waitDone(0);

    // abort while x == 3 in SETTLE keeps the partial results of codes 0..2.
    g = 8'($urandom);
    startSweep(0, g);
    repeat (19) @(negedge clk);
    checkOutput("pre_abort_x", x_a, 3);
    applyStimulus(0, 1'b0, 1'b1);
    void'(qa.pop_back());
    part = refModel(g, A_TRUTH, 3, 0);
    checkOutput("abort_x", x_a, 0);
    checkOutput("abort_busy", busy_a, 0);
    checkOutput("abort_done", done_a, 0);
    checkOutput("abort_err", err_count_a, part.err);
    checkOutput("abort_first_fail", first_fail_a, part.first);
    checkOutput("abort_fail_seen", fail_seen_a, part.fs);
    repeat (60) @(negedge clk);
    checkOutput("abort_stays_idle", busy_a, 0);

    // Asynchronous reset while x == 5.
    startSweep(0, 8'($urandom_range(0, 255)));
    repeat (32) @(negedge clk);
    checkOutput("pre_reset_x", x_a, 5);
    #2 rst_n = 1'b0;
    #1;
    void'(qa.pop_back());
    checkOutput("mid_rst_x", x_a, 0);
    checkOutput("mid_rst_busy", busy_a, 0);
    checkOutput("mid_rst_done", done_a, 0);
    checkOutput("mid_rst_pass", pass_a, 0);
    checkOutput("mid_rst_err", err_count_a, 0);
    checkOutput("mid_rst_fail_seen", fail_seen_a, 0);
    checkOutput("mid_rst_first_fail", first_fail_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("post_rst_busy", busy_a, 0);
    checkOutput("post_rst_x", x_a, 0);
    checkOutput("post_rst_done", done_a, 0);

    startSweep(0, 8'h00); waitDone(0);
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gate3_vector_exerciser.md
# gate3_vector_exerciser

Synthesizable stimulus-and-check stage for a 3-input gate under test, such as the switch-level OR3.
- Upstream role: drives the gate's 3-bit input vector through all 8 codes in ascending order.
- Downstream role: samples the gate's output after a programmable settle time and compares it against a truth-table parameter.
- Reports mismatch count, first failing code and a pass/fail verdict.
- Used both in simulation benches and on-FPGA as a built-in self-test wrapper around gate macros.

## Interface
Parameters:
- SETTLE_CYCLES, default 5: clock cycles each vector is held before sampling; legal range 3..255. Values below 3 are clamped to 3 to cover the input synchronizer.
- TRUTH, default 8'hFE: expected output per input code; bit k is the expected y for x == k. 8'hFE = OR3.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to run a full 8-vector sweep.
- abort  input  1  stop the sweep and return to IDLE without asserting done.
- y_in  input  1  gate output; asynchronous to clk.
- x  output  3  vector driven to the gate under test.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high while in DONE.
- pass  output  1  valid when done is high; 1 iff err_count == 0.
- err_count  output  4  number of mismatching codes, 0..8.
- fail_seen  output  1  at least one mismatch in the current or last sweep.
- first_fail  output  3  lowest code that mismatched; 0 when fail_seen is 0.

## Operation
Reset behaviour:
- rst_n low asynchronously clears all outputs to 0, clears the sync flops, zeroes the counters and forces state IDLE. This applies at any point, including mid-sweep.

FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: start=1 → SETTLE. On the same edge: x←0, err_count←0, fail_seen←0, first_fail←0, settle counter←SETTLE_CYCLES-1, busy←1.
- SETTLE: the counter decrements each cycle. When the counter is 0 → SAMPLE.
- SAMPLE: compare y_sync (y_in after the 2-flop synchronizer) with TRUTH[x].
  - On mismatch: err_count+1. If fail_seen is 0, first_fail←x and fail_seen←1.
  - If x==7 → DONE, busy←0, done←1, pass←(final err_count==0).
  - Otherwise x←x+1, counter reloads, → SETTLE.
- DONE: x holds 7 and all results hold. start=1 restarts exactly as from IDLE, clearing done and pass on the same edge.

Input rules:
- start in SETTLE or SAMPLE is ignored.
- abort has priority over start and over the SAMPLE compare. When abort=1 in SETTLE or SAMPLE: → IDLE, busy←0, done←0, x←0. Results keep their partial values, and that cycle's sample is not counted.
- abort in IDLE or DONE has no effect.

Arithmetic:
- err_count is 4-bit unsigned and cannot exceed 8, so no saturation logic is needed.
- x increments without wrap; the sweep ends at 7.

## Timing
- start is sampled at edge 0. x=0 is visible from edge 0 onward.
- Each vector is held SETTLE_CYCLES+1 cycles: SETTLE_CYCLES cycles in SETTLE, then 1 in SAMPLE.
- done rises at edge 8*(SETTLE_CYCLES+1). With the default of 5, that is edge 48.
- y_in reaches y_sync 2 cycles after it changes. The minimum settle of 3 therefore guarantees that the sampled value reflects the current x.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Package gate_tst_pkg holds:
  - state enum (IDLE, SETTLE, SAMPLE, DONE);
  - TRUTH_OR3 = 8'hFE, TRUTH_NOR3 = 8'h01, TRUTH_AND3 = 8'h80;
  - SETTLE_MIN = 3.
- Sub-module sync2: 2-flop synchronizer, async active-low reset to 0, instantiated once for y_in.
- The FSM, settle counter and result registers live in the top module.

## Test plan
- Correct OR3 model, defaults, start pulse → x steps 0..7, each code held 6 cycles; done at edge 48; pass=1, err_count=0, fail_seen=0.
- y_in stuck at 0 → err_count=7, fail_seen=1, first_fail=1, pass=0.
- NOR3 gate under test with TRUTH=8'hFE → err_count=8, first_fail=0, pass=0. Rerun with TRUTH=8'h01 → pass=1.
- start pulsed again at x=4 → ignored, sweep continues and completes normally. start in DONE → done drops next edge, err_count clears, new sweep begins.
- abort at x=3 in SETTLE → next edge state IDLE, x=0, busy=0, done=0, err_count unchanged.
- rst_n low mid-sweep at x=5 → all outputs 0 immediately without a clock edge; after release, the block stays IDLE until start.
